// File: rtl/snake_pkg.sv
// Shared types for the snake body path: coordinate width, packed {x,y}
// segment and the body sequencer state encoding.
package snake_pkg;
    localparam int COORD_W = 7;
    localparam int SEG_W   = 2 * COORD_W;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_READ, S_WAIT, S_WRITE, S_HEAD, S_DONE
    } state_t;
endpackage

// File: rtl/snake_body_sequencer.sv
// Owns the snake body RAM port: renderer reads win every cycle, and the move
// sequencer shifts the body toward the tail and writes the new head in between.
module snake_body_sequencer
    import snake_pkg::*;
#(
    parameter int SNAKE_LENGTH_BIT = 7,
    parameter int MAX_LENGTH       = 64,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 20,
    parameter int INIT_Y           = 15
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        game_tik,
    input  logic                        fruit_eaten,
    input  logic [COORD_W-1:0]          new_head_x,
    input  logic [COORD_W-1:0]          new_head_y,
    input  logic                        display_area,
    input  logic                        rd_req,
    input  logic [SNAKE_LENGTH_BIT-1:0] rd_addr,
    output logic [SEG_W-1:0]            rd_data,
    output logic                        rd_valid,
    output logic [SNAKE_LENGTH_BIT-1:0] mem_addr,
    output logic                        mem_we,
    output logic [SEG_W-1:0]            mem_wdata,
    input  logic [SEG_W-1:0]            mem_rdata,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);
    localparam logic [SNAKE_LENGTH_BIT-1:0] ONE       = SNAKE_LENGTH_BIT'(1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] MAX_LEN   = SNAKE_LENGTH_BIT'(MAX_LENGTH);
    localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LEN  = SNAKE_LENGTH_BIT'(INIT_LENGTH);
    localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LAST = SNAKE_LENGTH_BIT'(INIT_LENGTH - 1);

    state_t                        state, state_nx;
    logic [SNAKE_LENGTH_BIT-1:0]   idx, init_cnt, start_idx;
    seg_t                          hold, head, init_seg;
    logic                          grow, pending, start;

    assign init_seg.x = COORD_W'(INIT_X) - COORD_W'(init_cnt);
    assign init_seg.y = COORD_W'(INIT_Y);
    assign start_idx  = grow ? snake_length : snake_length - ONE;
    assign start      = (state == S_IDLE) && pending && !display_area;
    assign rd_data    = mem_rdata;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nx  = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_INIT:  if (!rd_req && init_cnt == INIT_LAST) state_nx = S_IDLE;
            S_IDLE:  if (start) state_nx = (start_idx == '0) ? S_HEAD : S_READ;
            S_READ:  if (!rd_req) state_nx = S_WAIT;
            S_WAIT:  state_nx = S_WRITE;
            S_WRITE: if (!rd_req) state_nx = (idx == ONE) ? S_HEAD : S_READ;
            S_HEAD:  if (!rd_req) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
        // Port stays quiet while reset is held so the RAM sees no stray write.
        if (!reset) begin
            if (rd_req) begin
                mem_addr = rd_addr;
            end else begin
                case (state)
                    S_INIT:  begin mem_we = 1'b1; mem_addr = init_cnt; mem_wdata = init_seg; end
                    S_READ:  mem_addr = idx - ONE;
                    S_WRITE: begin mem_we = 1'b1; mem_addr = idx; mem_wdata = hold; end
                    S_HEAD:  begin mem_we = 1'b1; mem_wdata = head; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            init_cnt     <= '0;
            idx          <= '0;
            hold         <= '0;
            head         <= '0;
            grow         <= 1'b0;
            pending      <= 1'b0;
            snake_length <= INIT_LEN;
            rd_valid     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_valid <= rd_req;
            overrun  <= game_tik && (pending || state != S_IDLE);
            if (game_tik && !pending && state == S_IDLE) begin
                pending <= 1'b1;
                head    <= {new_head_x, new_head_y};
                grow    <= fruit_eaten && (snake_length < MAX_LEN);
            end else if (start) begin
                pending <= 1'b0;
                idx     <= start_idx;
            end
            if (state == S_INIT && !rd_req)
                init_cnt <= init_cnt + ONE;
            // Captured before any renderer read issued in WAIT can return.
            if (state == S_WAIT)
                hold <= mem_rdata;
            if (state == S_WRITE && !rd_req)
                idx <= idx - ONE;
            if (state == S_HEAD && !rd_req)
                snake_length <= snake_length + SNAKE_LENGTH_BIT'(grow);
        end
    end
endmodule
